raster_pixel_sink: RTL and testbench

//  Receiving end of the rasterizer's serial pixel output. Deserializes the three parallel
//  16-bit streams (PX, PY, C), converts Q10.6 pixel coords to integer screen coords, clips
//  to the screen, and issues framebuffer write requests with a ready/valid handshake.

---
 rtl/raster_pixel_sink_if.sv | 33 +++
 rtl/raster_pixel_sink.sv | 180 ++++++++++++++++++
 tb/tb_raster_pixel_sink.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/raster_pixel_sink_if.sv
// Bundle of the serial pixel input stream, the framebuffer write handshake
// and the per-triangle status outputs of the raster pixel sink.
interface raster_pixel_sink_if #(
   parameter int ADDR_W = 17
);
   logic              PX;
   logic              PY;
   logic              C;
   logic              SYNC;
   logic              VALID;
   logic              DONE;
   logic              FB_WE;
   logic              FB_READY;
   logic [ADDR_W-1:0] FB_ADDR;
   logic [15:0]       FB_WDATA;
   logic              TRI_DONE;
   logic [16:0]       PIX_CNT;
   logic [16:0]       CLIP_CNT;
   logic              FRAME_ERR;
   logic              OVERRUN;

   // Rasterizer / framebuffer side
   modport master (
      output PX, PY, C, SYNC, VALID, DONE, FB_READY,
      input  FB_WE, FB_ADDR, FB_WDATA, TRI_DONE, PIX_CNT, CLIP_CNT, FRAME_ERR, OVERRUN
   );

   // Pixel sink side
   modport slave (
      input  PX, PY, C, SYNC, VALID, DONE, FB_READY,
      output FB_WE, FB_ADDR, FB_WDATA, TRI_DONE, PIX_CNT, CLIP_CNT, FRAME_ERR, OVERRUN
   );
endinterface

// File: rtl/raster_pixel_sink.sv
// Raster pixel sink: deserializes the PX/PY/C bit streams, converts Q10.6
// coordinates to integer screen positions, clips, and issues framebuffer
// writes over a ready/valid handshake with per-triangle pixel statistics.
module raster_pixel_sink #(
   parameter int FRAC   = 6,
   parameter int SCR_W  = 320,
   parameter int SCR_H  = 240,
   parameter int ADDR_W = 17
) (
   input logic                 CLK,
   input logic                 RST,
   raster_pixel_sink_if.slave  bus
);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_EVAL} state_t;

   localparam logic [16:0] CNT_MAX = '1;

   state_t            state_q, state_d;
   logic [3:0]        bitcnt_q, bitcnt_d;
   logic [15:0]       sx_q, sx_d;
   logic [15:0]       sy_q, sy_d;
   logic [15:0]       sc_q, sc_d;
   logic              valid_q, valid_d;
   logic              fb_we_q, fb_we_d;
   logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
   logic [15:0]       fb_wdata_q, fb_wdata_d;
   logic              tri_done_q, tri_done_d;
   logic              done_pend_q, done_pend_d;
   logic [16:0]       pix_q, pix_d;
   logic [16:0]       clip_q, clip_d;
   logic              frame_err_q, frame_err_d;
   logic              overrun_q, overrun_d;

   // Coordinate decode of the fully assembled word (valid during EVAL)
   logic        in_range;
   logic [31:0] ix_u;
   logic [31:0] iy_u;
   assign ix_u     = 32'(sx_q[15:FRAC]);
   assign iy_u     = 32'(sy_q[15:FRAC]);
   assign in_range = !sx_q[15] && !sy_q[15] &&
                     (ix_u < 32'(SCR_W)) && (iy_u < 32'(SCR_H));

   // Next-state logic: deserializer FSM, write register, counters, flags
   always_comb begin
      logic eval;
      logic want_write;
      logic accept;
      logic tri_cond;

      state_d     = state_q;
      bitcnt_d    = bitcnt_q;
      sx_d        = sx_q;
      sy_d        = sy_q;
      sc_d        = sc_q;
      valid_d     = valid_q;
      fb_we_d     = fb_we_q;
      fb_addr_d   = fb_addr_q;
      fb_wdata_d  = fb_wdata_q;
      tri_done_d  = 1'b0;
      done_pend_d = done_pend_q;
      pix_d       = pix_q;
      clip_d      = clip_q;
      frame_err_d = frame_err_q;
      overrun_d   = overrun_q;
      eval        = 1'b0;

      // A SYNC in any state (re)starts a word at bit 15; mid-word it is a framing error
      if (bus.SYNC) begin
         if (state_q == S_SHIFT)
            frame_err_d = 1'b1;
         eval     = (state_q == S_EVAL);
         state_d  = S_SHIFT;
         bitcnt_d = 4'd1;
         valid_d  = bus.VALID;
         sx_d     = {sx_q[14:0], bus.PX};
         sy_d     = {sy_q[14:0], bus.PY};
         sc_d     = {sc_q[14:0], bus.C};
      end else begin
         unique case (state_q)
            S_SHIFT: begin
               sx_d = {sx_q[14:0], bus.PX};
               sy_d = {sy_q[14:0], bus.PY};
               sc_d = {sc_q[14:0], bus.C};
               if (bitcnt_q == 4'd15) begin
                  state_d  = S_EVAL;
                  bitcnt_d = 4'd0;
               end else begin
                  bitcnt_d = bitcnt_q + 4'd1;
               end
            end
            S_EVAL: begin
               eval    = 1'b1;
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end

      accept     = fb_we_q && bus.FB_READY;
      want_write = eval && valid_q && in_range;

      if (accept)
         fb_we_d = 1'b0;

      // A new pixel can only load if the pending write retires this cycle or none is pending
      if (want_write) begin
         if (fb_we_q && !bus.FB_READY) begin
            overrun_d = 1'b1;
         end else begin
            fb_we_d    = 1'b1;
            fb_addr_d  = ADDR_W'(iy_u * 32'(SCR_W) + ix_u);
            fb_wdata_d = sc_q;
         end
      end

      // Triangle completes once idle with nothing in flight and no new word starting
      tri_cond    = done_pend_q && (state_q == S_IDLE) && !bus.SYNC && !fb_we_q;
      tri_done_d  = tri_cond;
      done_pend_d = bus.DONE || (done_pend_q && !tri_cond);

      // Counters hold through the TRI_DONE cycle, then clear for the next triangle
      if (tri_done_q) begin
         pix_d  = '0;
         clip_d = '0;
      end else begin
         if (accept && pix_q != CNT_MAX)
            pix_d = pix_q + 17'd1;
         if (eval && valid_q && !in_range && clip_q != CNT_MAX)
            clip_d = clip_q + 17'd1;
      end
   end

   // State register with asynchronous reset
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= S_IDLE;
         bitcnt_q    <= '0;
         sx_q        <= '0;
         sy_q        <= '0;
         sc_q        <= '0;
         valid_q     <= 1'b0;
         fb_we_q     <= 1'b0;
         fb_addr_q   <= '0;
         fb_wdata_q  <= '0;
         tri_done_q  <= 1'b0;
         done_pend_q <= 1'b0;
         pix_q       <= '0;
         clip_q      <= '0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         bitcnt_q    <= bitcnt_d;
         sx_q        <= sx_d;
         sy_q        <= sy_d;
         sc_q        <= sc_d;
         valid_q     <= valid_d;
         fb_we_q     <= fb_we_d;
         fb_addr_q   <= fb_addr_d;
         fb_wdata_q  <= fb_wdata_d;
         tri_done_q  <= tri_done_d;
         done_pend_q <= done_pend_d;
         pix_q       <= pix_d;
         clip_q      <= clip_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign bus.FB_WE     = fb_we_q;
   assign bus.FB_ADDR   = fb_addr_q;
   assign bus.FB_WDATA  = fb_wdata_q;
   assign bus.TRI_DONE  = tri_done_q;
   assign bus.PIX_CNT   = pix_q;
   assign bus.CLIP_CNT  = clip_q;
   assign bus.FRAME_ERR = frame_err_q;
   assign bus.OVERRUN   = overrun_q;

endmodule

// File: tb/tb_raster_pixel_sink.sv
// Scoreboard bench for raster_pixel_sink: directed words push expected
// framebuffer writes and triangle summaries; a negedge monitor checks them.
module tb_raster_pixel_sink;

   logic CLK;
   logic RST;

   raster_pixel_sink_if #(.ADDR_W(17)) bus ();

   raster_pixel_sink #(
      .FRAC(6), .SCR_W(320), .SCR_H(240), .ADDR_W(17)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;
   int tri_seen = 0;
   logic clr_chk = 1'b0;

   logic [16:0] exp_addr[$];
   logic [15:0] exp_data[$];
   logic [16:0] exp_pix[$];
   logic [16:0] exp_clip[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end else begin
         $display("check %s: 0x%0h ok", name, act);
      end
   endtask

   // Monitor: compares every accepted write and every TRI_DONE against the scoreboard
   always @(negedge CLK) begin
      if (!RST) begin
         if (clr_chk) begin
            chk("cnt_clear", {15'd0, bus.PIX_CNT} | {15'd0, bus.CLIP_CNT}, 32'd0);
            clr_chk = 1'b0;
         end
         if (bus.FB_WE && bus.FB_READY) begin
            if (exp_addr.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got addr %0d data 0x%0h expected none",
                        bus.FB_ADDR, bus.FB_WDATA);
            end else begin
               chk("wr_addr", 32'(bus.FB_ADDR), 32'(exp_addr.pop_front()));
               chk("wr_data", 32'(bus.FB_WDATA), 32'(exp_data.pop_front()));
            end
         end
         if (bus.TRI_DONE) begin
            tri_seen++;
            clr_chk = 1'b1;
            if (exp_pix.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_tri_done: got pulse expected none");
            end else begin
               chk("tri_pix", 32'(bus.PIX_CNT), 32'(exp_pix.pop_front()));
               chk("tri_clip", 32'(bus.CLIP_CNT), 32'(exp_clip.pop_front()));
            end
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send_word(input logic [15:0] px, input logic [15:0] py,
                            input logic [15:0] c, input logic v, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         bus.PX    = px[15-i];
         bus.PY    = py[15-i];
         bus.C     = c[15-i];
         bus.SYNC  = (i == 0);
         bus.VALID = (i == 0) ? v : 1'b0;
         tick();
      end
      bus.SYNC  = 1'b0;
      bus.VALID = 1'b0;
   endtask

   task automatic pulse_done();
      bus.DONE = 1'b1;
      tick();
      bus.DONE = 1'b0;
   endtask

   task automatic wait_tri(input string name);
      int start;
      bit seen;
      start = tri_seen;
      seen  = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (tri_seen != start) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s: got no TRI_DONE expected pulse within 60 cycles", name);
      end
      tick();
   endtask

   task automatic push_wr(input logic [16:0] a, input logic [15:0] d);
      exp_addr.push_back(a);
      exp_data.push_back(d);
   endtask

   task automatic push_tri(input logic [16:0] p, input logic [16:0] c);
      exp_pix.push_back(p);
      exp_clip.push_back(c);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      RST          = 1'b1;
      bus.PX       = 1'b0;
      bus.PY       = 1'b0;
      bus.C        = 1'b0;
      bus.SYNC     = 1'b0;
      bus.VALID    = 1'b0;
      bus.DONE     = 1'b0;
      bus.FB_READY = 1'b1;
      repeat (3) tick();

      // Reset state
      chk("rst_fb_we", 32'(bus.FB_WE), 32'd0);
      chk("rst_addr", 32'(bus.FB_ADDR), 32'd0);
      chk("rst_cnts", 32'(bus.PIX_CNT) + 32'(bus.CLIP_CNT), 32'd0);
      chk("rst_flags", {30'd0, bus.FRAME_ERR, bus.OVERRUN}, 32'd0);
      RST = 1'b0;
      tick();

      // 1. basic write (41,5) -> 1641, latency 17 cycles after SYNC
      push_wr(17'd1641, 16'hF800);
      send_word(16'h0A40, 16'h0140, 16'hF800, 1'b1, 16);
      chk("t1_we_eval", 32'(bus.FB_WE), 32'd0);
      tick();
      chk("t1_we_rise", 32'(bus.FB_WE), 32'd1);
      tick();
      chk("t1_pix_cnt", 32'(bus.PIX_CNT), 32'd1);
      push_tri(17'd1, 17'd0);
      pulse_done();
      wait_tri("t1_tri");

      // 2. VALID=0 word, then DONE: no write
      push_tri(17'd0, 17'd0);
      send_word(16'h0A40, 16'h0140, 16'h1234, 1'b0, 16);
      pulse_done();
      wait_tri("t2_tri");

      // 3. x=320 and y=-1 are both clipped
      push_tri(17'd0, 17'd2);
      send_word(16'h5000, 16'h0000, 16'h00FF, 1'b1, 16);
      send_word(16'h0000, 16'hFFC0, 16'h00FF, 1'b1, 16);
      tick();
      chk("t3_clip_cnt", 32'(bus.CLIP_CNT), 32'd2);
      pulse_done();
      wait_tri("t3_tri");

      // 4. back-to-back words while the framebuffer stalls -> overrun
      bus.FB_READY = 1'b0;
      push_wr(17'd650, 16'h1111);
      send_word(16'h0280, 16'h0080, 16'h1111, 1'b1, 16);
      send_word(16'h02C0, 16'h0080, 16'h2222, 1'b1, 16);
      tick();
      chk("t4_overrun", 32'(bus.OVERRUN), 32'd1);
      chk("t4_hold_we", 32'(bus.FB_WE), 32'd1);
      chk("t4_hold_addr", 32'(bus.FB_ADDR), 32'd650);
      chk("t4_hold_data", 32'(bus.FB_WDATA), 32'h1111);
      chk("t4_pix_stall", 32'(bus.PIX_CNT), 32'd0);
      bus.FB_READY = 1'b1;
      tick();
      chk("t4_pix_cnt", 32'(bus.PIX_CNT), 32'd1);
      push_tri(17'd1, 17'd0);
      pulse_done();
      wait_tri("t4_tri");

      // 5. SYNC reasserted at bit 8 -> framing error, new word still written
      chk("t5_ferr_before", 32'(bus.FRAME_ERR), 32'd0);
      push_wr(17'd64100, 16'hABCD);
      send_word(16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 7);
      send_word(16'h1900, 16'h3200, 16'hABCD, 1'b1, 16);
      chk("t5_frame_err", 32'(bus.FRAME_ERR), 32'd1);
      push_tri(17'd1, 17'd0);
      pulse_done();
      wait_tri("t5_tri");

      // 6. async reset mid-shift with a write pending, then corner pixel (319,239)
      bus.FB_READY = 1'b0;
      send_word(16'h0040, 16'h0040, 16'h5555, 1'b1, 16);
      tick();
      chk("t6_we_pending", 32'(bus.FB_WE), 32'd1);
      send_word(16'h0080, 16'h0080, 16'h6666, 1'b1, 5);
      #2;
      RST = 1'b1;
      #1;
      chk("t6_rst_we", 32'(bus.FB_WE), 32'd0);
      chk("t6_rst_flags", {30'd0, bus.FRAME_ERR, bus.OVERRUN}, 32'd0);
      chk("t6_rst_addr", 32'(bus.FB_ADDR), 32'd0);
      tick();
      tick();
      RST = 1'b0;
      bus.FB_READY = 1'b1;
      tick();
      push_wr(17'd76799, 16'h0F0F);
      send_word(16'h4FC0, 16'h3BC0, 16'h0F0F, 1'b1, 16);
      push_tri(17'd1, 17'd0);
      pulse_done();
      wait_tri("t6_tri");

      repeat (3) tick();
      chk("end_wr_queue", 32'(exp_addr.size()), 32'd0);
      chk("end_tri_queue", 32'(exp_pix.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
